// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, decoded packet layout, field bounds and stage states shared with execute
package decode_pkg;
  typedef enum logic [5:0] {
    NOP   = 6'd0,
    ADD   = 6'd1,
    SUB   = 6'd2,
    LOAD  = 6'd3,
    STORE = 6'd4,
    BEQ   = 6'd5,
    JMP   = 6'd6,
    HALT  = 6'd7
  } opcode_t;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int DST_MSB    = 25;
  localparam int DST_LSB    = 21;
  localparam int SRC0_MSB   = 20;
  localparam int SRC0_LSB   = 16;
  localparam int SRC1_MSB   = 15;
  localparam int SRC1_LSB   = 11;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  typedef struct packed {
    logic [63:0] pc;
    logic [5:0]  opcode;
    logic [4:0]  dst;
    logic [4:0]  src0;
    logic [4:0]  src1;
    logic [63:0] imm;
    logic        is_branch;
    logic        is_mem;
    logic        illegal;
  } DecodedInsn;
  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
endpackage

// File: rtl/decode_logic.sv
// decode_logic: combinational crack of one instruction word and its PC into a DecodedInsn
module decode_logic
  import decode_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int INSN_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [INSN_WIDTH-1:0] insn,
  output DecodedInsn            d
);
  logic [5:0] op;
  assign op = insn[OPCODE_MSB:OPCODE_LSB];
  always_comb begin
    d           = '0;
    d.pc        = 64'(pc);
    d.opcode    = op;
    d.dst       = insn[DST_MSB:DST_LSB];
    d.src0      = insn[SRC0_MSB:SRC0_LSB];
    d.src1      = insn[SRC1_MSB:SRC1_LSB];
    d.imm       = {{48{insn[IMM_MSB]}}, insn[IMM_MSB:IMM_LSB]};
    d.is_branch = (op == BEQ) || (op == JMP);
    d.is_mem    = (op == LOAD) || (op == STORE);
    d.illegal   = op > HALT;
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: valid/ready decode stage with 2-entry skid buffer; DECODE_STATS_EN adds stat counters
module decode_stage
  import decode_pkg::*;
#(
  parameter int core_id    = 0,
  parameter int ADDR_WIDTH = 64,
  parameter int INSN_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fetch_valid,
  output logic                  fetch_ready,
  input  logic [ADDR_WIDTH-1:0] fetch_pc,
  input  logic [INSN_WIDTH-1:0] fetch_insn,
  input  logic                  flush,
  output logic                  exec_valid,
  input  logic                  exec_ready,
  output logic [ADDR_WIDTH-1:0] exec_pc,
  output logic [5:0]            exec_opcode,
  output logic [4:0]            exec_dst,
  output logic [4:0]            exec_src0,
  output logic [4:0]            exec_src1,
  output logic [63:0]           exec_imm,
  output logic                  exec_is_branch,
  output logic                  exec_is_mem,
  output logic                  exec_illegal
`ifdef DECODE_STATS_EN
  ,
  output logic [31:0]           stat_decoded,
  output logic [31:0]           stat_illegal,
  output logic [31:0]           stat_stall_cycles
`endif
);
  if (core_id < 0 || INSN_WIDTH != 32) begin : g_bad_cfg
    $error("decode_stage: unsupported configuration");
  end
  state_t     state, state_d;
  DecodedInsn dec, out_q, skid_q;
  logic       acc, take, ld_out, ld_skid, from_skid;
  decode_logic #(.ADDR_WIDTH(ADDR_WIDTH), .INSN_WIDTH(INSN_WIDTH)) u_dec (
    .pc   (fetch_pc),
    .insn (fetch_insn),
    .d    (dec)
  );
  assign acc  = fetch_valid & fetch_ready;
  assign take = exec_valid & exec_ready;
  always_ff @(posedge clk)
    state <= !reset_n ? EMPTY : state_d;
  always_comb begin
    state_d = flush ? EMPTY :
              state == EMPTY ? (acc ? FULL : EMPTY) :
              state == FULL  ? (acc & !take ? SKID : !acc & take ? EMPTY : FULL) :
                               (take ? FULL : SKID);
    from_skid = state == SKID;
    ld_out    = !flush & ((state == EMPTY & acc) | (state == FULL & acc & take) | (state == SKID & take));
    ld_skid   = !flush & state == FULL & acc & !take;
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (ld_out) out_q <= from_skid ? skid_q : dec;
      if (ld_skid) skid_q <= dec;
    end
  // ready derives from state and reset only, never from exec_ready
  always_comb begin
    fetch_ready    = reset_n & (state != SKID);
    exec_valid     = state != EMPTY;
    exec_pc        = out_q.pc[ADDR_WIDTH-1:0];
    exec_opcode    = out_q.opcode;
    exec_dst       = out_q.dst;
    exec_src0      = out_q.src0;
    exec_src1      = out_q.src1;
    exec_imm       = out_q.imm;
    exec_is_branch = out_q.is_branch;
    exec_is_mem    = out_q.is_mem;
    exec_illegal   = out_q.illegal;
  end
`ifdef DECODE_STATS_EN
  always_ff @(posedge clk)
    if (!reset_n) begin
      stat_decoded      <= '0;
      stat_illegal      <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (take) stat_decoded <= stat_decoded + 32'd1;
      if (take & out_q.illegal) stat_illegal <= stat_illegal + 32'd1;
      if (exec_valid & !exec_ready) stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
`endif
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage (set DECODE_STATS_EN to also check counters)
module tb_decode_stage;
  logic        clk = 0;
  logic        reset_n, fetch_valid, fetch_ready, flush, exec_valid, exec_ready;
  logic [63:0] fetch_pc, exec_pc, exec_imm;
  logic [31:0] fetch_insn;
  logic [5:0]  exec_opcode;
  logic [4:0]  exec_dst, exec_src0, exec_src1;
  logic        exec_is_branch, exec_is_mem, exec_illegal;
`ifdef DECODE_STATS_EN
  logic [31:0] stat_decoded, stat_illegal, stat_stall_cycles;
`endif
  logic [31:0] m_dec, m_ill, m_stall;
  int checks = 0, errors = 0, taken = 0;
  typedef struct { logic [63:0] pc; logic [31:0] insn; } pkt_t;
  pkt_t q[$];
  always #5 clk = ~clk;
  decode_stage dut (
    .clk(clk), .reset_n(reset_n), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_pc(fetch_pc), .fetch_insn(fetch_insn), .flush(flush), .exec_valid(exec_valid),
    .exec_ready(exec_ready), .exec_pc(exec_pc), .exec_opcode(exec_opcode), .exec_dst(exec_dst),
    .exec_src0(exec_src0), .exec_src1(exec_src1), .exec_imm(exec_imm),
    .exec_is_branch(exec_is_branch), .exec_is_mem(exec_is_mem), .exec_illegal(exec_illegal)
`ifdef DECODE_STATS_EN
    , .stat_decoded(stat_decoded), .stat_illegal(stat_illegal), .stat_stall_cycles(stat_stall_cycles)
`endif
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(input logic v, input logic [63:0] pc, input logic [31:0] insn,
                      input logic rdy, input logic fl);
    pkt_t p;
    logic [5:0] op;
    fetch_valid = v; fetch_pc = pc; fetch_insn = insn; exec_ready = rdy; flush = fl;
    @(posedge clk);
    if (!reset_n) begin
      q.delete();
      m_dec = 0; m_ill = 0; m_stall = 0;
    end else begin
      bit tk, ac;
      tk = q.size() > 0 && rdy;
      ac = v && q.size() < 2;
      if (q.size() > 0 && !rdy) m_stall++;
      if (tk) begin
        taken++;
        m_dec++;
        if (q[0].insn[31:26] >= 6'd8) m_ill++;
      end
      if (fl) q.delete();
      else begin
        if (tk) void'(q.pop_front());
        if (ac) q.push_back('{pc, insn});
      end
    end
    #1;
    check("exec_valid", exec_valid, q.size() != 0);
    check("fetch_ready", fetch_ready, reset_n && q.size() < 2);
    if (q.size() != 0) begin
      p  = q[0];
      op = p.insn[31:26];
      check("pc", exec_pc, p.pc);
      check("opcode", exec_opcode, op);
      check("dst", exec_dst, p.insn[25:21]);
      check("src0", exec_src0, p.insn[20:16]);
      check("src1", exec_src1, p.insn[15:11]);
      check("imm", exec_imm, {{48{p.insn[15]}}, p.insn[15:0]});
      check("is_branch", exec_is_branch, op == 6'd5 || op == 6'd6);
      check("is_mem", exec_is_mem, op == 6'd3 || op == 6'd4);
      check("illegal", exec_illegal, op >= 6'd8);
    end
`ifdef DECODE_STATS_EN
    check("stat_decoded", stat_decoded, m_dec);
    check("stat_illegal", stat_illegal, m_ill);
    check("stat_stall", stat_stall_cycles, m_stall);
`endif
  endtask
  initial begin
    int k, t0;
    logic [31:0] d0, i0;
    reset_n = 0;
    step(1, 64'h10, 32'h04221800, 0, 0);
    step(1, 64'h10, 32'h04221800, 0, 0);
    check("rst_opcode", exec_opcode, 0);
    check("rst_pc", exec_pc, 0);
    check("rst_imm", exec_imm, 0);
    reset_n = 1;
    step(0, 0, 0, 1, 0);
    step(1, 64'h1000, 32'h04221800, 1, 0);
    check("add_op", exec_opcode, 1);
    check("add_dst", exec_dst, 1);
    check("add_src0", exec_src0, 2);
    check("add_src1", exec_src1, 3);
    step(1, 64'h1004, 32'h0C41FFFC, 1, 0);
    check("load_imm", exec_imm, 64'hFFFFFFFFFFFFFFFC);
    check("load_mem", exec_is_mem, 1);
    step(0, 0, 0, 1, 0);
    k = 0;
    t0 = taken;
    for (int c = 0; c < 14; c++) begin
      bit ac;
      ac = k < 4 && q.size() < 2;
      step(k < 4, 64'h2000 + 64'(4 * k), {6'd2, 5'(k), 5'(k + 1), 16'h8000 + 16'(k)}, c >= 6, 0);
      if (ac) k++;
    end
    check("bp_out_cnt", taken - t0, 4);
    step(1, 64'h3000, 32'h04000001, 0, 0);
    step(1, 64'h3004, 32'h04000002, 0, 0);
    check("skid_ready", fetch_ready, 0);
    step(1, 64'hDEAD, 32'h18000BAD, 0, 1);
    check("flush_valid", exec_valid, 0);
    check("flush_ready", fetch_ready, 1);
    t0 = taken;
    for (int c = 0; c < 3; c++) step(0, 0, 0, 1, 0);
    check("flush_dropped", taken - t0, 0);
    d0 = m_dec; i0 = m_ill;
    step(1, 64'h4000, {6'h3F, 26'h123}, 1, 0);
    check("illegal_bit", exec_illegal, 1);
    step(1, 64'h4004, {6'd5, 26'h2000}, 1, 0);
    check("beq_branch", exec_is_branch, 1);
    check("beq_mem", exec_is_mem, 0);
    step(0, 0, 0, 1, 0);
    check("two_takes", m_dec - d0, 2);
    check("one_illegal", m_ill - i0, 1);
    for (int c = 0; c < 10000; c++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 3) != 0) w[31:26] = 6'($urandom_range(0, 7));
      step($urandom_range(0, 9) < 7, {$urandom, $urandom}, w, $urandom_range(0, 9) < 6,
           $urandom_range(0, 99) < 3);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
